// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: two-master / one-slave Wishbone arbiter for the shared
// instruction memory. Master 0 is the instruction-fetch bus and master 1 is
// the data bus or program loader. Ownership lasts for the whole Wishbone cycle,
// so CTI/BTE bursts reach the memory in one piece.
// Optional build macro: WB_ARB_ROUND_ROBIN_EN. When it is defined, a tie in
// IDLE goes to the master that was not granted last. When it is undefined,
// master 0 wins every tie.
module wb_mem_arbiter #(
  parameter int aw = 32,
  parameter int dw = 32
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic [aw-1:0] m0_adr_i,
  input  logic [dw-1:0] m0_dat_i,
  input  logic [3:0]    m0_sel_i,
  input  logic          m0_we_i,
  input  logic [1:0]    m0_bte_i,
  input  logic [2:0]    m0_cti_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  output logic [dw-1:0] m0_dat_o,
  input  logic [aw-1:0] m1_adr_i,
  input  logic [dw-1:0] m1_dat_i,
  input  logic [3:0]    m1_sel_i,
  input  logic          m1_we_i,
  input  logic [1:0]    m1_bte_i,
  input  logic [2:0]    m1_cti_i,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic [dw-1:0] m1_dat_o,
  output logic [aw-1:0] s_adr_o,
  output logic [dw-1:0] s_dat_o,
  output logic [3:0]    s_sel_o,
  output logic          s_we_o,
  output logic [1:0]    s_bte_o,
  output logic [2:0]    s_cti_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  input  logic          s_ack_i,
  input  logic          s_err_i,
  input  logic [dw-1:0] s_dat_i,
  output logic [1:0]    gnt_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GNT0 = 2'd1;
  localparam logic [1:0] ST_GNT1 = 2'd2;

  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic       r_last;
  logic       w_last_next;
  logic       w_tie_m1;

  // A tie goes to master 1 only in the round-robin build, and only when
  // master 0 held the previous grant.
`ifdef WB_ARB_ROUND_ROBIN_EN
  assign w_tie_m1 = ~r_last;
`else
  assign w_tie_m1 = 1'b0;
`endif

  // State and last-granted registers. Reset makes master 0 win the first tie.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_last  <= w_last_next;
    end
  end

  // Next-state logic. A new grant is issued only from IDLE. A grant is held
  // until the owner drops cyc, regardless of CTI.
  always_comb begin
    w_state_next = r_state;
    w_last_next  = r_last;
    case (r_state)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          if (w_tie_m1) begin
            w_state_next = ST_GNT1;
            w_last_next  = 1'b1;
          end else begin
            w_state_next = ST_GNT0;
            w_last_next  = 1'b0;
          end
        end else if (m0_cyc_i) begin
          w_state_next = ST_GNT0;
          w_last_next  = 1'b0;
        end else if (m1_cyc_i) begin
          w_state_next = ST_GNT1;
          w_last_next  = 1'b1;
        end
      end
      ST_GNT0: if (!m0_cyc_i) w_state_next = ST_IDLE;
      ST_GNT1: if (!m1_cyc_i) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Output mux. When nothing is granted, master 0's request fields are
  // driven with cyc/stb held low. Ack and err reach only the owner, and the
  // path is combinational so the memory's own ack timing is preserved.
  always_comb begin
    s_adr_o  = m0_adr_i;
    s_dat_o  = m0_dat_i;
    s_sel_o  = m0_sel_i;
    s_we_o   = m0_we_i;
    s_bte_o  = m0_bte_i;
    s_cti_o  = m0_cti_i;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (r_state)
      ST_GNT0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i;
      end
      ST_GNT1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_bte_o  = m1_bte_i;
        s_cti_o  = m1_cti_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i;
      end
      default: ;
    endcase
  end

  // Read data is broadcast to both masters. Only the granted master sees an
  // ack, so only that master consumes the data.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // The grant comes straight from the registered state.
  assign gnt_o = {r_state == ST_GNT1, r_state == ST_GNT0};

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed testbench for wb_mem_arbiter. A small word memory plays the
// slave role, and the bench drives the slave ack/err by hand.
module tb_wb_mem_arbiter;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_we_i, m1_we_i, m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i;
  logic [1:0]  m0_bte_i, m1_bte_i;
  logic [2:0]  m0_cti_i, m1_cti_i;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i;
  logic [1:0]  s_bte_o, gnt_o;
  logic [2:0]  s_cti_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:255];

  always #5 wb_clk_i = ~wb_clk_i;

  wb_mem_arbiter #(.aw(32), .dw(32)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_bte_i(m0_bte_i), .m0_cti_i(m0_cti_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_bte_i(m1_bte_i), .m1_cti_i(m1_cti_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_bte_o(s_bte_o), .s_cti_o(s_cti_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_dat_i(s_dat_i), .gnt_o(gnt_o)
  );

  // Slave memory: asynchronous read, and a byte-selected write on an acked write strobe.
  assign s_dat_i = mem[s_adr_o[9:2]];
  always @(posedge wb_clk_i) begin
    if (s_cyc_o && s_stb_o && s_we_o && s_ack_i) begin
      for (int b = 0; b < 4; b++)
        if (s_sel_o[b]) mem[s_adr_o[9:2]][8*b +: 8] <= s_dat_o[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    logic [1:0] exp_tie2;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
    wb_rst_i = 1'b1;
    m0_adr_i = 32'h0C; m0_dat_i = 32'h1111_1111; m0_sel_i = 4'hF; m0_we_i = 1'b0;
    m0_bte_i = 2'b00; m0_cti_i = 3'b000; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    m1_adr_i = 32'h0; m1_dat_i = 32'h0; m1_sel_i = 4'hF; m1_we_i = 1'b0;
    m1_bte_i = 2'b01; m1_cti_i = 3'b000; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    s_ack_i = 1'b0; s_err_i = 1'b0;

    // Reset: a request and a slave ack arriving during reset must be ignored.
    tick;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; s_ack_i = 1'b1;
    tick;
    check("rst_gnt", gnt_o, 2'b00);
    check("rst_scyc", s_cyc_o, 1'b0);
    check("rst_sstb", s_stb_o, 1'b0);
    check("rst_m0ack", m0_ack_o, 1'b0);
    check("rst_m1ack", m1_ack_o, 1'b0);
    wb_rst_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0; s_ack_i = 1'b0;
    tick;
    $display("txn reset done");

    // m0 single classic read of 0x100.
    m0_adr_i = 32'h100; m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_cti_i = 3'b000;
    settle;
    check("lat_gnt_before", gnt_o, 2'b00);
    check("lat_scyc_before", s_cyc_o, 1'b0);
    tick;
    check("rd_gnt", gnt_o, 2'b01);
    check("rd_scyc", s_cyc_o, 1'b1);
    check("rd_sadr", s_adr_o, 32'h100);
    s_ack_i = 1'b1;
    settle;
    check("rd_m0ack", m0_ack_o, 1'b1);
    check("rd_m1ack", m1_ack_o, 1'b0);
    check("rd_data", m0_dat_o, 32'hA000_0040);
    tick;
    s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    settle;
    check("rd_hold_gnt", gnt_o, 2'b01);
    tick;
    check("rd_release", gnt_o, 2'b00);
    $display("txn m0 single read done");

    // m0 incrementing burst of four beats; m1 starts requesting at the second beat.
    m0_adr_i = 32'h0; m0_cti_i = 3'b010; m0_bte_i = 2'b00; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    tick;
    check("bst_gnt", gnt_o, 2'b01);
    for (int b = 0; b < 4; b++) begin
      m0_adr_i = 32'(b * 4);
      m0_cti_i = (b == 3) ? 3'b111 : 3'b010;
      if (b == 1) begin m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h200; end
      s_ack_i = 1'b1;
      settle;
      check($sformatf("bst_m0ack%0d", b), m0_ack_o, 1'b1);
      check($sformatf("bst_m1ack%0d", b), m1_ack_o, 1'b0);
      check($sformatf("bst_gnt%0d", b), gnt_o, 2'b01);
      tick;
    end
    s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_cti_i = 3'b000; m0_adr_i = 32'h0C;
    settle;
    check("ho_gnt_hold", gnt_o, 2'b01);
    tick;
    check("ho_dead_gnt", gnt_o, 2'b00);
    check("ho_dead_scyc", s_cyc_o, 1'b0);
    tick;
    check("ho_m1_gnt", gnt_o, 2'b10);
    check("ho_m1_scyc", s_cyc_o, 1'b1);
    $display("txn m0 burst + handover done");

    // m1 write of 0xDEADBEEF with sel 0011 to 0x40.
    m1_adr_i = 32'h40; m1_dat_i = 32'hDEAD_BEEF; m1_sel_i = 4'b0011; m1_we_i = 1'b1;
    m1_cti_i = 3'b000; m1_bte_i = 2'b01;
    settle;
    check("wr_sadr", s_adr_o, 32'h40);
    check("wr_sdat", s_dat_o, 32'hDEAD_BEEF);
    check("wr_ssel", s_sel_o, 4'b0011);
    check("wr_swe", s_we_o, 1'b1);
    check("wr_sbte", s_bte_o, 2'b01);
    s_ack_i = 1'b1;
    settle;
    check("wr_m1ack", m1_ack_o, 1'b1);
    check("wr_m0ack", m0_ack_o, 1'b0);
    tick;
    s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0; m1_sel_i = 4'hF;
    tick;
    m0_adr_i = 32'h40; m0_we_i = 1'b0; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    tick;
    check("rb_gnt", gnt_o, 2'b01);
    s_ack_i = 1'b1;
    settle;
    check("rb_data", m0_dat_o, 32'hA000_BEEF);
    tick;
    s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_adr_i = 32'h0C;
    tick;
    $display("txn m1 write + m0 readback done");

    // Tie from reset, then a second tie after m0 releases.
    wb_rst_i = 1'b1;
    tick;
    wb_rst_i = 1'b0;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    tick;
    check("tie1_gnt", gnt_o, 2'b01);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    tick;
    check("tie_idle", gnt_o, 2'b00);
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
`ifdef WB_ARB_ROUND_ROBIN_EN
    exp_tie2 = 2'b10;
`else
    exp_tie2 = 2'b01;
`endif
    tick;
    check("tie2_gnt", gnt_o, exp_tie2);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick;
    tick;
    $display("txn tie arbitration done");

    // Reset during the third beat of an m1 burst.
    m1_adr_i = 32'h80; m1_cti_i = 3'b010; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    tick;
    check("rb1_gnt", gnt_o, 2'b10);
    s_ack_i = 1'b1;
    tick;
    tick;
    wb_rst_i = 1'b1;
    settle;
    check("rmb_beat3_ack", m1_ack_o, 1'b1);
    tick;
    check("rmb_scyc", s_cyc_o, 1'b0);
    check("rmb_gnt", gnt_o, 2'b00);
    check("rmb_m1ack", m1_ack_o, 1'b0);
    wb_rst_i = 1'b0; s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_cti_i = 3'b000;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    tick;
    check("rmb_m0_gnt", gnt_o, 2'b01);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    $display("txn reset mid-burst done");

    // Slave error while m1 owns the bus.
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    tick;
    tick;
    check("err_gnt", gnt_o, 2'b10);
    s_err_i = 1'b1;
    settle;
    check("err_m1", m1_err_o, 1'b1);
    check("err_m0", m0_err_o, 1'b0);
    s_err_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick;
    tick;
    $display("txn slave error done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
